// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: owns the PC and fetches over a req/ack port with one request outstanding.
// Define FETCH_PERF_CNT_EN to add the perf_flush_cnt / perf_stall_cnt counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_src,
  input  logic        jmp,
  input  logic        jr,
  input  logic        if_flush,
  input  logic [31:0] br_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] hold_buf, hold_nxt;
  logic [31:0] inst_nxt, pc4_nxt;
  logic        valid_nxt;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign redirect  = if_flush & ~stall;
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  always_comb begin
    target = id_pc4;
    if (jr)
      target = jr_target;
    else if (jmp)
      target = {id_pc4[31:28], id_inst[25:0], 2'b00};
    else if (pc_src)
      target = br_target;
  end

  // An unstalled cycle that loads nothing new leaves a bubble so ID never re-executes an instruction.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    hold_nxt  = hold_buf;
    inst_nxt  = id_inst;
    pc4_nxt   = id_pc4;
    valid_nxt = id_valid;
    imem_req  = 1'b0;
    if (!stall) begin
      valid_nxt = 1'b0;
      inst_nxt  = NOP_INST;
    end
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (stall) begin
            hold_nxt  = imem_rdata;
            state_nxt = HOLD;
          end else if (!redirect) begin
            inst_nxt  = imem_rdata;
            pc4_nxt   = pc_plus4;
            valid_nxt = 1'b1;
            pc_nxt    = pc_plus4;
          end
        end else if (redirect) begin
          state_nxt = DRAIN;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_nxt = REQ;
          if (!redirect) begin
            inst_nxt  = hold_buf;
            pc4_nxt   = pc_plus4;
            valid_nxt = 1'b1;
            pc_nxt    = pc_plus4;
          end
        end
      end
      DRAIN: begin
        if (imem_ack)
          state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect)
      pc_nxt = target & ~32'd3;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      hold_buf <= 32'd0;
      id_inst  <= NOP_INST;
      id_pc4   <= 32'd0;
      id_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      hold_buf <= hold_nxt;
      id_inst  <= inst_nxt;
      id_pc4   <= pc4_nxt;
      id_valid <= valid_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_flush_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (redirect)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (stall && id_valid)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
